// File: rtl/riscv_formal_monitor_rv32imc.sv
// RVFI retirement checker for a single-issue RV32IMC core: tracks order, next PC
// and a shadow register file, and latches the first detected violation code.
module riscv_formal_monitor_rv32imc (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic        rvfi_mem_extamo,
  output logic [15:0] errcode
);

  logic [63:0] expected_order;
  logic [31:0] next_pc;
  logic        pc_known;
  logic        halted;
  logic [31:0] shadow [1:31];
  logic [31:1] shadow_valid;

  logic [13:1] chk;
  logic [15:0] first_code;

  // Fields that carry no checkable property in this monitor.
  logic unused_inputs;
  assign unused_inputs = ^{rvfi_insn[15:2], rvfi_mem_rdata, rvfi_mem_wdata};

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
      default:                   mask_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    chk = '0;
    chk[1] = (rvfi_order != expected_order);
    chk[2] = pc_known && (rvfi_pc_rdata != next_pc);
    // Shadow reads see the pre-update contents, so rd==rs in one record checks the old value.
    if (rvfi_rs1_addr != 5'd0) begin
      if (shadow_valid[rvfi_rs1_addr])
        chk[3] = (rvfi_rs1_rdata != shadow[rvfi_rs1_addr]);
    end
    if (rvfi_rs2_addr != 5'd0) begin
      if (shadow_valid[rvfi_rs2_addr])
        chk[4] = (rvfi_rs2_rdata != shadow[rvfi_rs2_addr]);
    end
    chk[5]  = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
              ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0));
    chk[6]  = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    chk[7]  = (rvfi_mem_rmask != '0) && (rvfi_mem_wmask != '0);
    chk[8]  = ((rvfi_mem_rmask != '0) && !mask_legal(rvfi_mem_rmask)) ||
              ((rvfi_mem_wmask != '0) && !mask_legal(rvfi_mem_wmask));
    chk[9]  = ((rvfi_mem_rmask != '0) || (rvfi_mem_wmask != '0)) &&
              (rvfi_mem_addr[1:0] != 2'b00);
    chk[10] = rvfi_pc_rdata[0] || rvfi_pc_wdata[0];
    chk[11] = (rvfi_insn[1:0] != 2'b11) && (rvfi_insn[31:16] != '0);
    chk[12] = rvfi_trap || rvfi_intr || rvfi_mem_extamo || (rvfi_mode != 2'b00);
    chk[13] = halted;

    // Scan downwards so the lowest firing code is the one left standing.
    first_code = '0;
    for (int unsigned i = 13; i >= 1; i--) begin
      if (chk[i]) first_code = 16'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      errcode        <= '0;
      expected_order <= '0;
      next_pc        <= '0;
      pc_known       <= 1'b0;
      halted         <= 1'b0;
      shadow_valid   <= '0;
    end else if (rvfi_valid) begin
      if ((errcode == '0) && (first_code != '0))
        errcode <= first_code;
      expected_order <= rvfi_order + 64'd1;
      next_pc        <= rvfi_pc_wdata;
      pc_known       <= 1'b1;
      halted         <= halted | rvfi_halt;
      if (rvfi_rd_addr != 5'd0)
        shadow_valid[rvfi_rd_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && rvfi_valid && (rvfi_rd_addr != 5'd0))
      shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

endmodule

// File: tb/tb_riscv_formal_monitor_rv32imc.sv
// Bench for riscv_formal_monitor_rv32imc: directed scenarios plus randomized
// retirement streams checked against an architectural reference model.
module tb_riscv_formal_monitor_rv32imc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic        rvfi_intr = 1'b0;
  logic [1:0]  rvfi_mode = '0;
  logic [4:0]  rvfi_rs1_addr = '0;
  logic [4:0]  rvfi_rs2_addr = '0;
  logic [31:0] rvfi_rs1_rdata = '0;
  logic [31:0] rvfi_rs2_rdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic [31:0] rvfi_mem_addr = '0;
  logic [3:0]  rvfi_mem_rmask = '0;
  logic [3:0]  rvfi_mem_wmask = '0;
  logic [31:0] rvfi_mem_rdata = '0;
  logic [31:0] rvfi_mem_wdata = '0;
  logic        rvfi_mem_extamo = 1'b0;
  logic [15:0] errcode;

  riscv_formal_monitor_rv32imc dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_extamo(rvfi_mem_extamo), .errcode(errcode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, halt, intr, extamo;
    logic [1:0]  mode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic [31:0] pc_r, pc_w, addr, mrdata, mwdata;
    logic [3:0]  rmask, wmask;
  } rec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural view of what the core has retired so far.
  logic [63:0] m_order;
  logic [31:0] m_pc;
  bit          m_pc_known;
  bit          m_halted;
  logic [31:0] m_regs [32];
  bit          m_written [32];
  logic [15:0] m_err;

  function automatic bit size_ok(input logic [3:0] m);
    if ($countones(m) == 1) return 1'b1;
    return (m == 4'd3) || (m == 4'd12) || (m == 4'd15);
  endfunction

  function automatic logic [15:0] model_code(input rec_t r);
    if (r.order != m_order) return 16'd1;
    if (m_pc_known && r.pc_r != m_pc) return 16'd2;
    if (r.rs1 != 0 && m_written[r.rs1] && r.rs1_data != m_regs[r.rs1]) return 16'd3;
    if (r.rs2 != 0 && m_written[r.rs2] && r.rs2_data != m_regs[r.rs2]) return 16'd4;
    if ((r.rs1 == 0 && r.rs1_data != 0) || (r.rs2 == 0 && r.rs2_data != 0)) return 16'd5;
    if (r.rd == 0 && r.rd_data != 0) return 16'd6;
    if (r.rmask != 0 && r.wmask != 0) return 16'd7;
    if ((r.rmask != 0 && !size_ok(r.rmask)) || (r.wmask != 0 && !size_ok(r.wmask))) return 16'd8;
    if ((r.rmask != 0 || r.wmask != 0) && (r.addr % 4 != 0)) return 16'd9;
    if (r.pc_r % 2 == 1 || r.pc_w % 2 == 1) return 16'd10;
    if (r.insn % 4 != 3 && r.insn >= 32'h10000) return 16'd11;
    if (r.trap || r.intr || r.extamo || r.mode != 0) return 16'd12;
    if (m_halted) return 16'd13;
    return 16'd0;
  endfunction

  task automatic model_reset();
    m_order = 0; m_pc = 0; m_pc_known = 0; m_halted = 0; m_err = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_written[i] = 0; end
  endtask

  task automatic model_step(input rec_t r);
    logic [15:0] c;
    c = model_code(r);
    if (m_err == 0) m_err = c;
    m_order = r.order + 1;
    m_pc = r.pc_w; m_pc_known = 1;
    if (r.rd != 0) begin m_regs[r.rd] = r.rd_data; m_written[r.rd] = 1; end
    m_halted = m_halted || r.halt;
  endtask

  function automatic rec_t nxt();
    rec_t r;
    r.order = m_order; r.insn = 32'h00000013;
    r.trap = 0; r.halt = 0; r.intr = 0; r.extamo = 0; r.mode = 0;
    r.rs1 = 0; r.rs2 = 0; r.rd = 0;
    r.rs1_data = 0; r.rs2_data = 0; r.rd_data = 0;
    r.pc_r = m_pc_known ? m_pc : 32'h0; r.pc_w = r.pc_r + 4;
    r.addr = 0; r.mrdata = 0; r.mwdata = 0; r.rmask = 0; r.wmask = 0;
    return r;
  endfunction

  task automatic apply(input rec_t r);
    rvfi_order = r.order; rvfi_insn = r.insn; rvfi_trap = r.trap; rvfi_halt = r.halt;
    rvfi_intr = r.intr; rvfi_mode = r.mode; rvfi_rs1_addr = r.rs1; rvfi_rs2_addr = r.rs2;
    rvfi_rs1_rdata = r.rs1_data; rvfi_rs2_rdata = r.rs2_data; rvfi_rd_addr = r.rd;
    rvfi_rd_wdata = r.rd_data; rvfi_pc_rdata = r.pc_r; rvfi_pc_wdata = r.pc_w;
    rvfi_mem_addr = r.addr; rvfi_mem_rmask = r.rmask; rvfi_mem_wmask = r.wmask;
    rvfi_mem_rdata = r.mrdata; rvfi_mem_wdata = r.mwdata; rvfi_mem_extamo = r.extamo;
  endtask

  // Inputs change on the falling edge; errcode is read on the next falling edge.
  task automatic retire(input rec_t r);
    apply(r);
    rvfi_valid = 1'b1;
    model_step(r);
    @(negedge clock);
    rvfi_valid = 1'b0;
  endtask

  task automatic do_reset();
    rec_t g;
    g = nxt();
    g.order = 64'h1234; g.trap = 1; g.rd = 5'd9; g.rd_data = 32'hFFFF0000;
    @(negedge clock);
    apply(g);
    reset = 1'b1; rvfi_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; rvfi_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rec_t r;
    do_reset();
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL reset_errcode actual=%h required=%h", errcode, 16'h0000);
    end
    // The record presented with reset must be ignored: order 0 is still expected.
    r = nxt();
    retire(r);
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL reset_wins actual=%h required=%h", errcode, 16'h0000);
    end
  endtask

  task automatic test_clean_sequence();
    rec_t r;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r = nxt();
      retire(r);
      total++;
      if (errcode !== 16'h0000 || errcode !== m_err) begin
        bad++; $display("FAIL clean_seq[%0d] actual=%h required=%h", i, errcode, 16'h0000);
      end
    end
  endtask

  task automatic test_order_sticky();
    rec_t r;
    do_reset();
    r = nxt(); retire(r);
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL order_first actual=%h required=%h", errcode, 16'h0000);
    end
    r = nxt(); r.order = 64'd2; retire(r);
    total++;
    if (errcode !== 16'h0001) begin
      bad++; $display("FAIL order_skip actual=%h required=%h", errcode, 16'h0001);
    end
    for (int i = 0; i < 10; i++) begin r = nxt(); retire(r); end
    total++;
    if (errcode !== 16'h0001 || m_err !== 16'h0001) begin
      bad++; $display("FAIL order_sticky actual=%h required=%h", errcode, 16'h0001);
    end
    // A later, different violation must not overwrite the first code.
    r = nxt(); r.trap = 1; retire(r);
    total++;
    if (errcode !== 16'h0001) begin
      bad++; $display("FAIL order_no_overwrite actual=%h required=%h", errcode, 16'h0001);
    end
    do_reset();
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL order_reset_clear actual=%h required=%h", errcode, 16'h0000);
    end
  endtask

  task automatic test_reg_shadow();
    rec_t r;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      r = nxt(); r.rd = 5'd5; r.rd_data = 32'hDEADBEEF; retire(r);
      r = nxt(); r.rs1 = 5'd5; r.rs1_data = (pass == 0) ? 32'hDEADBEEE : 32'hDEADBEEF; retire(r);
      total++;
      if (errcode !== ((pass == 0) ? 16'h0003 : 16'h0000)) begin
        bad++; $display("FAIL reg_rs1_pass%0d actual=%h required=%h", pass, errcode,
                        (pass == 0) ? 16'h0003 : 16'h0000);
      end
    end
    // rs2 mismatch and an unwritten register read (unchecked).
    do_reset();
    r = nxt(); r.rs1 = 5'd12; r.rs1_data = 32'h5555AAAA; retire(r);
    r = nxt(); r.rd = 5'd3; r.rd_data = 32'h1; retire(r);
    r = nxt(); r.rs2 = 5'd3; r.rs2_data = 32'h2; retire(r);
    total++;
    if (errcode !== 16'h0004) begin
      bad++; $display("FAIL reg_rs2 actual=%h required=%h", errcode, 16'h0004);
    end
  endtask

  task automatic test_rd_eq_rs1();
    rec_t r;
    do_reset();
    r = nxt(); r.rd = 5'd7; r.rd_data = 32'h10; retire(r);
    r = nxt(); r.rd = 5'd7; r.rs1 = 5'd7; r.rs1_data = 32'h10; r.rd_data = 32'h11; retire(r);
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL rd_eq_rs1 actual=%h required=%h", errcode, 16'h0000);
    end
    r = nxt(); r.rs2 = 5'd7; r.rs2_data = 32'h11; retire(r);
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL rd_eq_rs1_new actual=%h required=%h", errcode, 16'h0000);
    end
    r = nxt(); r.rs1 = 5'd7; r.rs1_data = 32'h10; retire(r);
    total++;
    if (errcode !== 16'h0003) begin
      bad++; $display("FAIL rd_eq_rs1_stale actual=%h required=%h", errcode, 16'h0003);
    end
  endtask

  task automatic test_mem_masks();
    rec_t r;
    logic [15:0] want [3] = '{16'h0008, 16'h0009, 16'h0007};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      r = nxt();
      case (k)
        0: begin r.wmask = 4'b0110; r.addr = 32'h1000; end
        1: begin r.rmask = 4'b0001; r.addr = 32'h1001; end
        default: begin r.rmask = 4'b1111; r.wmask = 4'b1111; r.addr = 32'h1001; end
      endcase
      retire(r);
      total++;
      if (errcode !== want[k]) begin
        bad++; $display("FAIL mem_mask[%0d] actual=%h required=%h", k, errcode, want[k]);
      end
    end
  endtask

  task automatic test_halt_compressed();
    rec_t r;
    do_reset();
    r = nxt(); r.halt = 1; retire(r);
    total++;
    if (errcode !== 16'h0000) begin
      bad++; $display("FAIL halt_itself actual=%h required=%h", errcode, 16'h0000);
    end
    // An idle cycle must neither check nor update anything.
    @(negedge clock);
    r = nxt(); retire(r);
    total++;
    if (errcode !== 16'h000D) begin
      bad++; $display("FAIL after_halt actual=%h required=%h", errcode, 16'h000D);
    end
    do_reset();
    r = nxt(); r.insn = 32'h00010001; retire(r);
    total++;
    if (errcode !== 16'h000B) begin
      bad++; $display("FAIL compressed_upper actual=%h required=%h", errcode, 16'h000B);
    end
    do_reset();
    r = nxt(); r.insn = 32'h00004501; r.pc_w = r.pc_r + 2; retire(r);
    r = nxt(); r.pc_w = 32'h00000021; retire(r);
    total++;
    if (errcode !== 16'h000A) begin
      bad++; $display("FAIL odd_pc actual=%h required=%h", errcode, 16'h000A);
    end
  endtask

  task automatic test_random();
    rec_t r;
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int n = 0; n < int'($urandom_range(1, 10)); n++) begin
        r = nxt();
        if ($urandom_range(0, 24) == 0) r.order = {$urandom, $urandom};
        if ($urandom_range(0, 24) == 0) r.pc_r = $urandom & 32'hFFFFFFFE;
        r.pc_w = r.pc_r + (($urandom_range(0, 1) == 0) ? 32'd2 : 32'd4);
        if ($urandom_range(0, 29) == 0) r.pc_w = $urandom;
        r.rs1 = 5'($urandom_range(0, 31));
        r.rs2 = 5'($urandom_range(0, 31));
        r.rs1_data = ($urandom_range(0, 9) == 0) ? $urandom : m_regs[r.rs1];
        r.rs2_data = ($urandom_range(0, 9) == 0) ? $urandom : m_regs[r.rs2];
        r.rd = 5'($urandom_range(0, 31));
        r.rd_data = (r.rd == 0 && $urandom_range(0, 9) != 0) ? 32'h0 : $urandom;
        case ($urandom_range(0, 5))
          0: begin r.rmask = 4'b0011 << (2 * $urandom_range(0, 1)); r.addr = $urandom & ~32'h3; end
          1: begin r.wmask = 4'b0001 << $urandom_range(0, 3); r.addr = $urandom & ~32'h3; end
          2: begin r.rmask = 4'($urandom); r.wmask = 4'($urandom); r.addr = $urandom; end
          3: begin r.wmask = 4'b1111; r.addr = $urandom; end
          default: ;
        endcase
        if ($urandom_range(0, 19) == 0) r.insn = $urandom;
        else if ($urandom_range(0, 3) == 0) r.insn = $urandom & 32'h0000FFFC;
        if ($urandom_range(0, 29) == 0) r.trap = 1;
        if ($urandom_range(0, 29) == 0) r.mode = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 29) == 0) r.extamo = 1;
        if ($urandom_range(0, 14) == 0) r.halt = 1;
        retire(r);
        total++;
        if (errcode !== m_err) begin
          bad++; $display("FAIL random ep%0d rec%0d actual=%h required=%h", ep, n, errcode, m_err);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_sequence();
    test_order_sticky();
    test_reg_shadow();
    test_rd_eq_rs1();
    test_mem_masks();
    test_halt_compressed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_formal_monitor_rv32imc.md
Name: riscv_formal_monitor_rv32imc

Overview:
Simulation/formal-style checker on the RVFI retirement port of a single-issue RV32IMC core. It tracks architectural state (expected order, next PC, shadow register file) and flags inconsistencies in retired-instruction records. Its only output is a sticky 16-bit error code, which the testbench polls every cycle.

Parameters:
None. XLEN is fixed at 32 and NRET at 1.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rvfi_valid  in  1  one instruction retires this cycle
rvfi_order  in  64  retirement sequence number
rvfi_insn  in  32  instruction word; compressed instructions occupy [15:0]
rvfi_trap  in  1  instruction trapped
rvfi_halt  in  1  final instruction of the program
rvfi_intr  in  1  first instruction of a trap handler
rvfi_mode  in  2  privilege mode
rvfi_rs1_addr  in  5  rs1 index
rvfi_rs2_addr  in  5  rs2 index
rvfi_rs1_rdata  in  32  rs1 value read
rvfi_rs2_rdata  in  32  rs2 value read
rvfi_rd_addr  in  5  rd index (0 = no write)
rvfi_rd_wdata  in  32  rd value written
rvfi_pc_rdata  in  32  PC of the retired instruction
rvfi_pc_wdata  in  32  next PC
rvfi_mem_addr  in  32  word-aligned memory address
rvfi_mem_rmask  in  4  load byte mask
rvfi_mem_wmask  in  4  store byte mask
rvfi_mem_rdata  in  32  load data
rvfi_mem_wdata  in  32  store data
rvfi_mem_extamo  in  1  extended AMO flag
errcode  out  16  0 = no error; otherwise the code of the first detected violation

Behaviour:
- Reset (synchronous): errcode=0, expected_order=0, pc_known=0, halted=0, all 31 shadow-valid bits cleared.
- Inputs are sampled only when rvfi_valid=1 and reset=0. All checks for a cycle are evaluated in parallel.
- Checks, each raised only if its condition holds:
  1: rvfi_order != expected_order.
  2: pc_known=1 and rvfi_pc_rdata != stored next-PC.
  3: rs1_addr!=0, shadow[rs1] valid, and rs1_rdata != shadow[rs1].
  4: same as 3, for rs2.
  5: rs1_addr==0 and rs1_rdata!=0, or rs2_addr==0 and rs2_rdata!=0.
  6: rd_addr==0 and rd_wdata!=0.
  7: rmask!=0 and wmask!=0 simultaneously (no AMOs in IMC).
  8: a nonzero rmask or wmask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  9: a mask is nonzero and mem_addr[1:0]!=0.
  10: pc_rdata[0]=1 or pc_wdata[0]=1.
  11: insn[1:0]!=2'b11 and insn[31:16]!=0.
  12: trap, intr or mem_extamo set, or mode!=2'b00.
  13: halted=1 (valid seen after a halt retirement).
- Latching: if errcode==0 and any check fires, errcode is loaded with the lowest-numbered firing code on that clock edge (1-cycle latency). Once nonzero, errcode holds until reset; later errors are ignored.
- State update on each valid retirement, regardless of errors:
  - expected_order <= order+1
  - next-PC <= pc_wdata; pc_known <= 1
  - if rd_addr!=0: shadow[rd] <= rd_wdata and shadow-valid[rd] <= 1
  - halted <= halted | rvfi_halt
- Register-read ordering: reads compare against shadow contents before this cycle's rd update, so rd==rs1 in one instruction is checked against the old value.
- Unwritten registers are unchecked. x0 has no storage.
- rvfi_valid=0: no checks, no state change.
- Reset asserted together with valid: reset wins and the record is ignored.
- Order wrap at 2^64 uses modular arithmetic.

Test Plan:
- Reset, then 3 retirements with order 0,1,2, pc 0x0→0x4→0x8→0xC, no reg reads → errcode stays 0x0000.
- Retire order 0 then order 2 → errcode=0x0001 one cycle after the second retirement; it stays 0x0001 after 10 further clean retirements; reset clears it to 0.
- Retire with rd=x5, wdata=0xDEADBEEF; next retire with rs1=x5, rs1_rdata=0xDEADBEEE → errcode=0x0003. Same with rs1_rdata=0xDEADBEEF → 0.
- Same instruction has rd=rs1=x7 while shadow x7=0x10, with rs1_rdata=0x10 and rd_wdata=0x11 → no error; next read of x7 must equal 0x11.
- Store with wmask=4'b0110 → 0x0008. Load with rmask=4'b0001 and mem_addr=0x1001 → 0x0009. rmask=wmask=4'b1111 → 0x0007 (lowest code wins).
- Retire with rvfi_halt=1, then another valid retirement → 0x000D. Compressed insn 0x00010001 → 0x000B.
